// File: rtl/sq_acc_arbiter.sv
// Two-requester round-robin arbiter in front of a square-by-odd-sum accumulator.
// The granted requester's n is squared as 1+3+5+...+(2n-1), then held until its req drops.
module sq_acc_arbiter #(
    parameter int WIDTH_X = 7,
    parameter int WIDTH_A = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [WIDTH_X-1:0] n0,
    input  logic               req1,
    input  logic [WIDTH_X-1:0] n1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [WIDTH_A-1:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               last_id_q, last_id_d;
    logic [WIDTH_X-1:0] n_q, n_d, k_q, k_d;
    logic [WIDTH_A-1:0] acc_q, acc_d, result_q, result_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               busy_q, busy_d, done_q, done_d, done_id_q, done_id_d;

    logic               win;
    logic               own_req;
    logic [WIDTH_X-1:0] n_win, k_inc;
    logic [WIDTH_A-1:0] acc_step;

    always_comb begin
        // On a tie the requester that was not served last wins.
        win      = (req0 && req1) ? ~last_id_q : req1;
        n_win    = win ? n1 : n0;
        k_inc    = k_q + WIDTH_X'(1);
        acc_step = acc_q + ((WIDTH_A'(k_q) << 1) | WIDTH_A'(1));
        // While busy, last_id_q holds the owner of the accumulator.
        own_req  = last_id_q ? req1 : req0;

        state_d   = state_q;
        last_id_d = last_id_q;
        n_d       = n_q;
        k_d       = k_q;
        acc_d     = acc_q;
        result_d  = result_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        busy_d    = busy_q;
        done_d    = done_q;
        done_id_d = done_id_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    last_id_d = win;
                    n_d       = n_win;
                    acc_d     = '0;
                    k_d       = '0;
                    gnt0_d    = ~win;
                    gnt1_d    = win;
                    busy_d    = 1'b1;
                    if (n_win == '0) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        done_id_d = win;
                        result_d  = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = acc_step;
                k_d   = k_inc;
                if (k_inc == n_q) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = last_id_q;
                    result_d  = acc_step;
                end
            end
            DONE: begin
                if (!own_req) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_id_q <= 1'b1;
            n_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            n_q       <= n_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;

endmodule

// File: tb/tb_sq_acc_arbiter.sv
// Scoreboard bench: the driver predicts service order and n*n results, a monitor checks each done.
module tb_sq_acc_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [6:0]  n0, n1;
    logic        gnt0, gnt1, busy, done, done_id;
    logic [13:0] result;

    sq_acc_arbiter #(.WIDTH_X(7), .WIDTH_A(14)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .n0(n0), .req1(req1), .n1(n1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .done(done), .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit id;
        int res;
        int lat;
    } exp_t;

    exp_t sb[$];
    bit   ord[$];
    bit   m_last;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: who gets served, in what order, and what each result must be.
    task automatic issue(input bit r0, input bit r1, input bit rereq, input int a0, input int a1);
        int na[2];
        bit w;
        na[0] = a0;
        na[1] = a1;
        ord.delete();
        if (r0 && r1) begin
            w = !m_last;
            ord.push_back(w);
            ord.push_back(!w);
            if (rereq) ord.push_back(w);
        end else if (r0) begin
            ord.push_back(1'b0);
        end else if (r1) begin
            ord.push_back(1'b1);
        end
        foreach (ord[i])
            sb.push_back('{id: ord[i], res: na[ord[i]] * na[ord[i]], lat: na[ord[i]]});
        if (ord.size() > 0) m_last = ord[ord.size()-1];
        n0   = 7'(a0);
        n1   = 7'(a1);
        req0 = r0;
        req1 = r1;
    endtask

    task automatic serve();
        for (int i = 0; i < ord.size(); i++) begin
            bit id;
            bit again;
            int t;
            id    = ord[i];
            again = 1'b0;
            for (int j = i + 1; j < ord.size(); j++)
                if (ord[j] == id) again = 1'b1;
            t = 0;
            while (!done && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!done) chk("done_timeout", done, 1);
            if (id) req1 = 1'b0; else req0 = 1'b0;
            // Operand changes while still busy must not matter.
            if (!again) begin
                if (id) n1 = 7'($urandom_range(0, 127)); else n0 = 7'($urandom_range(0, 127));
            end
            @(negedge clk);
            chk("drop_done", done, 0);
            chk("drop_gnt", id ? gnt1 : gnt0, 0);
            if (again) begin
                if (id) req1 = 1'b1; else req0 = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Monitor
    int   cyc = 0;
    int   gcyc = 0;
    bit   pg = 1'b0;
    bit   pd = 1'b0;
    int   held_res = 0;
    exp_t e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pg = 1'b0;
            pd = 1'b0;
        end else begin
            if (gnt0 || gnt1) chk("gnt_overlap", int'(gnt0 & gnt1), 0);
            if ((gnt0 || gnt1) && !pg) gcyc = cyc;
            if (done && !pd) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", int'(done_id), int'(e.id));
                    chk("result", int'(result), e.res);
                    chk("latency", cyc - gcyc, e.lat);
                    chk("gnt_owner", int'(e.id ? gnt1 : gnt0), 1);
                    chk("busy_in_done", int'(busy), 1);
                    held_res = int'(result);
                end
            end else if (done && pd) begin
                chk("hold_result", int'(result), held_res);
            end
            pg = gnt0 | gnt1;
            pd = done;
        end
    end

    initial begin
        int t;
        int a0, a1, sel;
        rst    = 1'b1;
        req0   = 1'b1;
        req1   = 1'b1;
        n0     = 7'd3;
        n1     = 7'd4;
        m_last = 1'b1;

        @(negedge clk);
        chk("reset_outs_1", int'({gnt0, gnt1, busy, done, done_id, result}), 0);
        @(negedge clk);
        chk("reset_outs_2", int'({gnt0, gnt1, busy, done, done_id, result}), 0);
        rst = 1'b0;

        // Tie after reset with re-request: 0, 1, 0.
        issue(1, 1, 1, 3, 4);
        @(negedge clk);
        chk("first_gnt", int'({gnt0, gnt1}), 2);
        serve();

        issue(1, 0, 0, 5, 0);
        serve();
        issue(0, 1, 0, 0, 0);
        serve();
        issue(1, 0, 0, 127, 0);
        serve();

        // Reset in the middle of RUN.
        req0 = 1'b1;
        n0   = 7'd10;
        req1 = 1'b0;
        t = 0;
        while (!gnt0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("midrun_gnt", int'(gnt0), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset_outs", int'({gnt0, gnt1, busy, done, done_id, result}), 0);
        m_last = 1'b1;
        rst = 1'b0;
        issue(1, 0, 0, 10, 0);
        serve();

        for (int p = 0; p < 25; p++) begin
            sel = int'($urandom_range(0, 2));
            a0 = int'($urandom_range(0, 9));
            a0 = (a0 == 0) ? 0 : (a0 == 1) ? 127 : int'($urandom_range(1, 20));
            a1 = int'($urandom_range(0, 9));
            a1 = (a1 == 0) ? 0 : (a1 == 1) ? 127 : int'($urandom_range(1, 20));
            issue(sel != 1, sel != 0, 1'($urandom_range(0, 1)), a0, a1);
            serve();
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sq_acc_arbiter.md
SQ_ACC_ARBITER -- requirements
Module: sq_acc_arbiter

Interface
REQ-001 Parameter WIDTH_X, default 7: operand width of each requester's n.
REQ-002 Parameter WIDTH_A, default 14: accumulator and result width; WIDTH_A SHALL equal 2*WIDTH_X.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0  input  1  requester 0 request level.
REQ-007 n0  input  WIDTH_X  requester 0 operand.
REQ-008 req1  input  1  requester 1 request level.
REQ-009 n1  input  WIDTH_X  requester 1 operand.
REQ-010 gnt0  output  1  requester 0 owns the accumulator.
REQ-011 gnt1  output  1  requester 1 owns the accumulator.
REQ-012 busy  output  1  high in RUN or DONE.
REQ-013 done  output  1  result valid for the granted requester.
REQ-014 done_id  output  1  index of the requester whose result is valid.
REQ-015 result  output  WIDTH_A  n*n for the granted requester.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-017 In IDLE with any req high, the block SHALL grant one requester, latch its n, clear acc and clear step counter k, all at that edge.
REQ-018 Arbitration SHALL be round-robin on a last_id register: if both req are high, the requester != last_id wins; if only one is high, that requester wins.
REQ-019 On grant, last_id SHALL be set to the winner, and gnt<winner> SHALL go high at that edge and stay high through DONE.
REQ-020 If the latched n == 0, IDLE SHALL go directly to DONE with result = 0.
REQ-021 Otherwise IDLE SHALL go to RUN; each RUN edge SHALL perform acc <= acc + 2*k + 1 and k <= k + 1, with 2*k+1 computed at WIDTH_A bits.
REQ-022 RUN SHALL go to DONE on the edge where k+1 == n; result SHALL then equal n*n.
REQ-023 Latency SHALL be n+1 rising edges from the grant-sampling edge to done high, with a minimum of 1 edge for n = 0.
REQ-024 In DONE, done = 1, result, done_id and gnt SHALL be held stable until the granted requester's req is sampled low.
REQ-025 On that sample, DONE SHALL go to IDLE and clear done and gnt. This is a 4-phase handshake.
REQ-026 In DONE, the block SHALL ignore the non-granted requester; its req SHALL remain pending and be served on the next IDLE evaluation.
REQ-027 The earliest back-to-back re-grant is the edge after DONE exits, so IDLE lasts at least one cycle between services.
REQ-028 A requester that drops req during RUN SHALL NOT abort the computation; DONE still occurs and exits on the next sample of that req low.
REQ-029 n and the other requester's inputs SHALL be ignored while busy; only the latched n is used.
REQ-030 No overflow is possible: (2^WIDTH_X - 1)^2 < 2^WIDTH_A, and there is no saturation logic.
REQ-031 gnt0 and gnt1 SHALL never both be high.

Reset
REQ-032 When rst is high at a rising edge, the block SHALL set state = IDLE, gnt0 = gnt1 = busy = done = done_id = 0, result = 0, acc = 0, k = 0 and last_id = 1, so that req0 wins the first tie.
REQ-033 Reset SHALL take priority over every transition, including in RUN or DONE; an aborted computation SHALL never produce done.

Verification
REQ-034 Reset check: hold rst 2 cycles with req0 = req1 = 1 -> all outputs 0 during reset, and gnt0 = 1 on the first edge after release.
REQ-035 Single request: req0 = 1, n0 = 5 -> gnt0 after edge E0, done after E5 with result = 25 and done_id = 0; drop req0 -> done = 0 and gnt0 = 0 after the next edge.
REQ-036 Tie and fairness: after reset, req0 = req1 = 1, n0 = 3, n1 = 4, each dropping its req for 1 cycle after done -> order 0 (9), then 1 (16), then 0 (9); gnt0 and gnt1 never overlap.
REQ-037 Zero operand: req1 = 1, n1 = 0 -> done one edge after grant, result = 0, busy never in RUN.
REQ-038 Maximum operand: req0 = 1, n0 = 127 -> done after 128 edges, result = 16129.
REQ-039 Mid-run reset: req0 = 1, n0 = 10, rst pulsed at the 3rd RUN edge -> all outputs 0 the next cycle, no done pulse; after release, service restarts with result = 100.
